// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx: 8N1 UART receiver, centre-sampled, with valid/framing strobes     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter logic [7:0] CLK_PER_BIT = 8'd100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_signal,
  output logic [7:0] rx_data,
  output logic       rx_dv,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [7:0] c_half_m1 = (CLK_PER_BIT >> 1) - 8'd1;
  localparam logic [7:0] c_bit_m1  = CLK_PER_BIT - 8'd1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_CLEAN = 3'd4
  } state_t;

  state_t     r_state, w_state_next;
  logic       r_sync1, r_sync2;
  logic [7:0] r_count, w_count_next;
  logic [2:0] r_index, w_index_next;
  logic [7:0] r_shift, w_shift_next;
  logic [7:0] r_rx_data, w_rx_data_next;
  logic       r_rx_dv, w_rx_dv_next;
  logic       r_frame_err, w_frame_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= ST_IDLE;
      r_count     <= 8'd0;
      r_index     <= 3'd0;
      r_shift     <= 8'd0;
      r_rx_data   <= 8'h00;
      r_rx_dv     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rx_signal;
      r_sync2     <= r_sync1;
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_index     <= w_index_next;
      r_shift     <= w_shift_next;
      r_rx_data   <= w_rx_data_next;
      r_rx_dv     <= w_rx_dv_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_count_next     = r_count;
    w_index_next     = r_index;
    w_shift_next     = r_shift;
    w_rx_data_next   = r_rx_data;
    w_rx_dv_next     = 1'b0;
    w_frame_err_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_count_next = 8'd0;
        w_index_next = 3'd0;
        if (!r_sync2) w_state_next = ST_START;
      end
      ST_START: begin
        if (r_count < c_half_m1) begin
          w_count_next = r_count + 8'd1;
        end else begin
          w_count_next = 8'd0;
          // A start bit that is high again at its centre was only a glitch
          w_state_next = r_sync2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_count < c_bit_m1) begin
          w_count_next = r_count + 8'd1;
        end else begin
          w_count_next          = 8'd0;
          w_shift_next[r_index] = r_sync2;
          if (r_index == 3'd7) begin
            w_index_next = 3'd0;
            w_state_next = ST_STOP;
          end else begin
            w_index_next = r_index + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (r_count < c_bit_m1) begin
          w_count_next = r_count + 8'd1;
        end else begin
          w_count_next = 8'd0;
          if (r_sync2) begin
            w_rx_data_next = r_shift;
            w_rx_dv_next   = 1'b1;
          end else begin
            w_frame_err_next = 1'b1;
          end
          w_state_next = ST_CLEAN;
        end
      end
      ST_CLEAN: begin
        // Wait out a held-low (break) line so it cannot start a new frame
        if (r_sync2) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign rx_data   = r_rx_data;
  assign rx_dv     = r_rx_dv;
  assign frame_err = r_frame_err;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx: directed self-checking bench for uart_rx (16 and 100 clk/bit)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       dv_a, dv_b, ferr_a, ferr_b, busy_a, busy_b;

  int errors = 0;
  int checks = 0;
  int dv_cnt_a = 0, ferr_cnt_a = 0, dv_cnt_b = 0, ferr_cnt_b = 0;
  logic [7:0] got_a[$];
  logic [7:0] last_b = 8'h00;

  uart_rx #(.CLK_PER_BIT(8'd16)) dut16 (
    .clk(clk), .rst_n(rst_n), .rx_signal(rx_a),
    .rx_data(data_a), .rx_dv(dv_a), .frame_err(ferr_a), .rx_busy(busy_a)
  );

  uart_rx #(.CLK_PER_BIT(8'd100)) dut100 (
    .clk(clk), .rst_n(rst_n), .rx_signal(rx_b),
    .rx_data(data_b), .rx_dv(dv_b), .frame_err(ferr_b), .rx_busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor: sampled on the falling edge, away from DUT updates
  always @(negedge clk) begin
    if (dv_a) begin
      dv_cnt_a++;
      got_a.push_back(data_a);
    end
    if (ferr_a) ferr_cnt_a++;
    if (dv_b) begin
      dv_cnt_b++;
      last_b = data_b;
    end
    if (ferr_b) ferr_cnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input int per);
    if (sel) rx_b = v; else rx_a = v;
    repeat (per) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b, input int per, input logic stop_v);
    drive(sel, 1'b0, per);
    for (int i = 0; i < 8; i++) drive(sel, b[i], per);
    drive(sel, stop_v, per);
  endtask

  int dv0, fe0;

  initial begin
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(data_a), 32'h00);
    check("reset_rx_dv", 32'(dv_a), 32'h0);
    check("reset_frame_err", 32'(ferr_a), 32'h0);
    check("reset_rx_busy", 32'(busy_a), 32'h0);
    check("reset_busy_100", 32'(busy_b), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Basic byte 0xA5
    send_frame(1'b0, 8'hA5, 16, 1'b1);
    repeat (20) @(negedge clk);
    check("basic_dv_count", 32'(dv_cnt_a), 32'd1);
    check("basic_rx_data", 32'(data_a), 32'hA5);
    check("basic_ferr_count", 32'(ferr_cnt_a), 32'd0);
    check("basic_busy_low", 32'(busy_a), 32'h0);

    // Back-to-back frames, no idle gap between them
    got_a.delete();
    send_frame(1'b0, 8'h00, 16, 1'b1);
    send_frame(1'b0, 8'hFF, 16, 1'b1);
    send_frame(1'b0, 8'h3C, 16, 1'b1);
    send_frame(1'b0, 8'h81, 16, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_dv_count", 32'(dv_cnt_a), 32'd5);
    check("b2b_ferr_count", 32'(ferr_cnt_a), 32'd0);
    check("b2b_queue_len", 32'(got_a.size()), 32'd4);
    if (got_a.size() == 4) begin
      check("b2b_byte0", 32'(got_a[0]), 32'h00);
      check("b2b_byte1", 32'(got_a[1]), 32'hFF);
      check("b2b_byte2", 32'(got_a[2]), 32'h3C);
      check("b2b_byte3", 32'(got_a[3]), 32'h81);
    end

    // Glitch shorter than half a bit
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 40);
    check("glitch_dv_count", 32'(dv_cnt_a), 32'd5);
    check("glitch_ferr_count", 32'(ferr_cnt_a), 32'd0);
    check("glitch_busy_low", 32'(busy_a), 32'h0);

    // Framing error followed by a long break
    send_frame(1'b0, 8'h5A, 16, 1'b0);
    drive(1'b0, 1'b0, 40 * 16);
    check("ferr_count", 32'(ferr_cnt_a), 32'd1);
    check("ferr_no_dv", 32'(dv_cnt_a), 32'd5);
    check("ferr_data_kept", 32'(data_a), 32'h81);
    check("ferr_busy_in_break", 32'(busy_a), 32'h1);
    drive(1'b0, 1'b1, 20);
    check("ferr_busy_released", 32'(busy_a), 32'h0);
    send_frame(1'b0, 8'h66, 16, 1'b1);
    repeat (20) @(negedge clk);
    check("after_break_dv", 32'(dv_cnt_a), 32'd6);
    check("after_break_data", 32'(data_a), 32'h66);
    check("after_break_ferr", 32'(ferr_cnt_a), 32'd1);

    // Reset in the middle of data bit 4 of 0xC3
    drive(1'b0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'(8'hC3 >> i), 16);
    drive(1'b0, 1'b0, 8);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data", 32'(data_a), 32'h00);
    check("midrst_rx_busy", 32'(busy_a), 32'h0);
    check("midrst_rx_dv", 32'(dv_a), 32'h0);
    drive(1'b0, 1'b0, 8);
    drive(1'b0, 1'b0, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b1, 16);
    drive(1'b0, 1'b1, 16);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("midrst_no_spurious_dv", 32'(dv_cnt_a), 32'd6);
    send_frame(1'b0, 8'h96, 16, 1'b1);
    repeat (20) @(negedge clk);
    check("midrst_recover_dv", 32'(dv_cnt_a), 32'd7);
    check("midrst_recover_data", 32'(data_a), 32'h96);

    // Baud tolerance at 100 clk/bit: transmitter 3% fast and 3% slow
    dv0 = dv_cnt_b;
    fe0 = ferr_cnt_b;
    send_frame(1'b1, 8'h55, 97, 1'b1);
    repeat (60) @(negedge clk);
    check("fast_baud_dv", 32'(dv_cnt_b), 32'(dv0 + 1));
    check("fast_baud_data", 32'(last_b), 32'h55);
    send_frame(1'b1, 8'hAA, 103, 1'b1);
    repeat (60) @(negedge clk);
    check("slow_baud_dv", 32'(dv_cnt_b), 32'(dv0 + 2));
    check("slow_baud_data", 32'(last_b), 32'hAA);
    check("baud_no_ferr", 32'(ferr_cnt_b), 32'(fe0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
